// File: rtl/base_reset_pkg.sv
// Shared types and helpers for the staggered reset sequencer.
// Provides the sequencer state encoding, the counter sizing function and
// the minimum synchroniser depth.
package base_reset_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } seq_state_t;

    // Below two flops the deassertion edge is not safely synchronised.
    localparam int MIN_SYNC_STAGES = 2;

    // Width needed so one counter can reach the largest of the three timing values.
    function automatic int cnt_width(input int t1, input int t2, input int w);
        int m;
        m = t1;
        if (t2 > m) m = t2;
        if (w > m)  m = w;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/base_reset_sync.sv
// Reset synchroniser: asserts rst_sync low asynchronously with reset_n and
// releases it after SYNC_STAGES rising edges with reset_n high.
// Depths below MIN_SYNC_STAGES are raised to that minimum.
module base_reset_sync
    import base_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic rst_sync
);

    localparam int DEPTH = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [DEPTH-1:0] sync_q;

    // Shift a one through the chain once reset_n is released; clear at once on assertion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[DEPTH-1];

endmodule

// File: rtl/base_reset_seq.sv
// Multi-channel staggered reset sequencer.
// All NCH reset outputs assert asynchronously with reset_n. After the
// synchronised release, they are held for T1 cycles, then released one by
// one every T2 cycles (bit 0 first); done rises one cycle after the last
// release. sw_req re-runs the whole sequence from the hold phase.
// Optional feature macro: BASE_RESET_SEQ_WDOG_EN enables a watchdog that
// re-runs the sequence when DONE lasts WDOG_CYCLES cycles without wdog_kick.
module base_reset_seq
    import base_reset_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int T1          = 16,
    parameter int T2          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           sw_req,
    output logic [NCH-1:0] reset_out,
    output logic           done,
    input  logic           wdog_kick,
    output logic           wdog_fired
);

    localparam int CW = cnt_width(T1, T2, WDOG_CYCLES);
    localparam int IW = $clog2(NCH + 1);

    localparam logic [CW-1:0]  T1_LAST  = CW'(T1 - 1);
    localparam logic [CW-1:0]  T2_LAST  = CW'(T2 - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NCH);
    localparam logic [NCH-1:0] CH0      = NCH'(1);

    seq_state_t    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          rst_sync;
    logic          wdog_hit;
    logic          restart;

    // Saturating increment so a counter never wraps back into a release window.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    base_reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .rst_sync (rst_sync)
    );

`ifdef BASE_RESET_SEQ_WDOG_EN
    localparam logic [CW-1:0] WD_LAST = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] wcnt;

    // Timeout is due on the edge where the idle count would reach WDOG_CYCLES.
    assign wdog_hit = (state == ST_DONE) && !wdog_kick && (wcnt == WD_LAST);

    // Count unkicked cycles in DONE; cleared outside DONE (so on entry), on kick and on timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt       <= '0;
            wdog_fired <= 1'b0;
        end else begin
            wdog_fired <= wdog_hit;
            if (state != ST_DONE || wdog_kick || wdog_hit) begin
                wcnt <= '0;
            end else begin
                wcnt <= sat_inc(wcnt);
            end
        end
    end
`else
    logic unused_kick;

    assign unused_kick = wdog_kick;
    assign wdog_hit    = 1'b0;
    assign wdog_fired  = 1'b0;
`endif

    // A watchdog timeout behaves exactly like a software request on that edge.
    assign restart = sw_req | wdog_hit;

    // Sequencer FSM: hold all channels, release them one per T2 period, then report done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            idx       <= '0;
            reset_out <= '1;
            done      <= 1'b0;
        end else if (restart) begin
            // Restart wins over any release due on this edge.
            state     <= ST_HOLD;
            cnt       <= '0;
            idx       <= '0;
            reset_out <= '1;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (!rst_sync) begin
                        cnt <= '0;
                    end else if (cnt == T1_LAST) begin
                        reset_out <= reset_out & ~CH0;
                        idx       <= IW'(1);
                        cnt       <= '0;
                        state     <= ST_RELEASE;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_RELEASE: begin
                    if (idx == IDX_LAST) begin
                        // Every channel has been released; report completion one edge later.
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else if (cnt == T2_LAST) begin
                        reset_out <= reset_out & ~(CH0 << idx);
                        idx       <= idx + IW'(1);
                        cnt       <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state     <= ST_HOLD;
                    cnt       <= '0;
                    idx       <= '0;
                    reset_out <= '1;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_base_reset_seq.sv
// Testbench for base_reset_seq: table of expected outputs at fixed edges
// after reset release, hand-written sequences for restart, async reset and
// watchdog corner cases, and a per-cycle scoreboard fed by a timing model.
module tb_base_reset_seq;

    localparam int NCH     = 4;
    localparam int T1      = 16;
    localparam int T2      = 4;
    localparam int S       = 2;
    localparam int WD      = 8;
    localparam int DONE_AT = T1 + (NCH - 1) * T2 + 1;

    logic           clk       = 1'b0;
    logic           reset_n   = 1'b1;
    logic           sw_req    = 1'b0;
    logic           wdog_kick = 1'b0;
    logic [NCH-1:0] reset_out;
    logic           done;
    logic           wdog_fired;

    base_reset_seq #(
        .NCH         (NCH),
        .T1          (T1),
        .T2          (T2),
        .SYNC_STAGES (S),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_req     (sw_req),
        .reset_out  (reset_out),
        .done       (done),
        .wdog_kick  (wdog_kick),
        .wdog_fired (wdog_fired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] ro;
        logic           dn;
        logic           wf;
    } exp_t;

    typedef struct {
        int             edge_n;
        logic [NCH-1:0] ro;
        logic           dn;
    } vec_t;

    exp_t sb_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   edge_no = 0;

    // Timing model: m_since counts edges since the sequence origin
    // (edge S after reset release, or the last edge sw_req/timeout was seen).
    int   m_sync  = 0;
    int   m_since = 0;
    int   m_wcnt  = 0;
    logic m_fired = 1'b0;

    function automatic exp_t model_out();
        exp_t e;
        for (int k = 0; k < NCH; k++) e.ro[k] = (m_since < T1 + k * T2);
        e.dn = (m_since >= DONE_AT);
        e.wf = m_fired;
        return e;
    endfunction

    task automatic model_edge();
        logic hit;
        hit = 1'b0;
        if (!reset_n) begin
            m_sync  = 0;
            m_since = 0;
            m_wcnt  = 0;
            m_fired = 1'b0;
        end else begin
`ifdef BASE_RESET_SEQ_WDOG_EN
            if (!(m_since >= DONE_AT) || wdog_kick) m_wcnt = 0;
            else if (m_wcnt == WD - 1) begin
                hit    = 1'b1;
                m_wcnt = 0;
            end else m_wcnt++;
`endif
            if (m_sync < S) m_sync++;
            else if (m_since < 10000) m_since++;
            if (sw_req || hit) m_since = 0;
            m_fired = hit;
        end
    endtask

    task automatic sb_check();
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty edge=%0d", edge_no + 1);
        end else begin
            e = sb_q.pop_front();
            if (reset_out !== e.ro || done !== e.dn || wdog_fired !== e.wf) begin
                bad++;
                $display("FAIL sb edge=%0d got ro=%h done=%b wf=%b want ro=%h done=%b wf=%b",
                         edge_no + 1, reset_out, done, wdog_fired, e.ro, e.dn, e.wf);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, predict, sample 1 time unit after the rising edge.
    task automatic tick(input logic rn, input logic sw, input logic kick);
        @(negedge clk);
        reset_n   = rn;
        sw_req    = sw;
        wdog_kick = kick;
        model_edge();
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        sb_check();
        edge_no++;
    endtask

    function automatic logic [7:0] obs();
        return {2'b00, wdog_fired, done, reset_out};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[9];
        int   nfire;

        tbl[0] = '{17, 4'hF, 1'b0};
        tbl[1] = '{18, 4'hE, 1'b0};
        tbl[2] = '{21, 4'hE, 1'b0};
        tbl[3] = '{22, 4'hC, 1'b0};
        tbl[4] = '{25, 4'hC, 1'b0};
        tbl[5] = '{26, 4'h8, 1'b0};
        tbl[6] = '{29, 4'h8, 1'b0};
        tbl[7] = '{30, 4'h0, 1'b0};
        tbl[8] = '{31, 4'h0, 1'b1};

        // Reset asserted between clock edges: outputs must react without a clock.
        #2 reset_n = 1'b0;
        #1;
        chk("reset_state", obs(), 8'h0F);
        repeat (5) tick(1'b0, 1'b0, 1'b0);

        // Test 1: release and walk the table of expected edges.
        edge_no = 0;
        foreach (tbl[i]) begin
            while (edge_no < tbl[i].edge_n) tick(1'b1, 1'b0, 1'b0);
            chk($sformatf("t1_edge%0d", tbl[i].edge_n), obs(), {3'b000, tbl[i].dn, tbl[i].ro});
        end

        // Test 3: one-cycle sw_req in DONE.
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk("t3_after_e", obs(), 8'h0F);
        repeat (15) tick(1'b1, 1'b0, 1'b0);
        chk("t3_e15", obs(), 8'h0F);
        tick(1'b1, 1'b0, 1'b0);
        chk("t3_e16", obs(), 8'h0E);
        repeat (11) tick(1'b1, 1'b0, 1'b0);
        chk("t3_e27", obs(), 8'h08);
        tick(1'b1, 1'b0, 1'b0);
        chk("t3_e28", obs(), 8'h00);
        tick(1'b1, 1'b0, 1'b0);
        chk("t3_e29", obs(), 8'h10);

        // Test 4: sw_req on the edge where bit1 is due.
        tick(1'b1, 1'b1, 1'b0);
        repeat (19) tick(1'b1, 1'b0, 1'b0);
        chk("t4_before", obs(), 8'h0E);
        tick(1'b1, 1'b1, 1'b0);
        chk("t4_collide", obs(), 8'h0F);
        repeat (15) tick(1'b1, 1'b0, 1'b0);
        chk("t4_hold15", obs(), 8'h0F);
        tick(1'b1, 1'b0, 1'b0);
        chk("t4_bit0", obs(), 8'h0E);
        repeat (13) tick(1'b1, 1'b0, 1'b0);
        chk("t4_done", obs(), 8'h10);

        // Test 5: sw_req held for 40 cycles.
        repeat (40) tick(1'b1, 1'b1, 1'b0);
        chk("t5_held", obs(), 8'h0F);
        repeat (15) tick(1'b1, 1'b0, 1'b0);
        chk("t5_hold15", obs(), 8'h0F);
        tick(1'b1, 1'b0, 1'b0);
        chk("t5_bit0", obs(), 8'h0E);
        repeat (13) tick(1'b1, 1'b0, 1'b0);
        chk("t5_done", obs(), 8'h10);

        // Test 2: asynchronous reset while reset_out = 4'hC, then full rerun.
        tick(1'b1, 1'b1, 1'b0);
        repeat (20) tick(1'b1, 1'b0, 1'b0);
        chk("t2_at_c", obs(), 8'h0C);
        #2 reset_n = 1'b0;
        #1;
        chk("t2_async", obs(), 8'h0F);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        edge_no = 0;
        foreach (tbl[i]) begin
            while (edge_no < tbl[i].edge_n) tick(1'b1, 1'b0, 1'b0);
            chk($sformatf("t2_edge%0d", tbl[i].edge_n), obs(), {3'b000, tbl[i].dn, tbl[i].ro});
        end

        // Test 6: watchdog behaviour (DONE was entered at edge 31).
`ifdef BASE_RESET_SEQ_WDOG_EN
        repeat (7) tick(1'b1, 1'b0, 1'b0);
        chk("t6_pre_fire", obs(), 8'h10);
        tick(1'b1, 1'b0, 1'b0);
        chk("t6_fire", obs(), 8'h2F);
        tick(1'b1, 1'b0, 1'b0);
        chk("t6_pulse_end", obs(), 8'h0F);
        repeat (28) tick(1'b1, 1'b0, 1'b0);
        chk("t6_redone", obs(), 8'h10);
`endif
        nfire = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0, (i % 5) == 4);
            if (wdog_fired) nfire++;
        end
        chk("t6_kick_nofire", 8'(nfire), 8'h00);
`ifndef BASE_RESET_SEQ_WDOG_EN
        nfire = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (wdog_fired) nfire++;
        end
        chk("t6_disabled", 8'(nfire), 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
